// File: rtl/simd_regfile_mp.sv
// Multi-port vector register file with per-port writes, highest-port-wins priority,
// optional same-cycle write-to-read bypass and a pending-bit scoreboard.
module simd_regfile_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NREAD  = 8,
    parameter int NWRITE = 4,
    parameter int BYPASS = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREAD-1:0][ADDR_W-1:0]  r_addr,
    output logic [NREAD-1:0][DATA_W-1:0]  r_data,
    output logic [NREAD-1:0]              r_busy,
    input  logic [NWRITE-1:0]             w_en,
    input  logic [NWRITE-1:0][ADDR_W-1:0] w_addr,
    input  logic [NWRITE-1:0][DATA_W-1:0] w_data,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic [ADDR_W:0]               busy_cnt,
    output logic                          wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;
    logic [ADDR_W:0]   cnt_next;
    logic              conflict;
    logic [NREAD-1:0]  bp_hit;

    // Writes clear first, then a reservation re-sets, so reserve beats write-back.
    always_comb begin
        pending_next = pending;
        for (int j = 0; j < NWRITE; j++) begin
            if (w_en[j]) pending_next[w_addr[j]] = 1'b0;
        end
        if (rsv_en) pending_next[rsv_addr] = 1'b1;

        cnt_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, pending_next[k]};
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            for (int k = j + 1; k < NWRITE; k++) begin
                if (w_en[j] && w_en[k] && (w_addr[j] == w_addr[k])) conflict = 1'b1;
            end
        end
    end

    // Ascending port order: the last assignment (highest index) wins on collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
            pending     <= '0;
            busy_cnt    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (w_en[j]) regs[w_addr[j]] <= w_data[j];
            end
            pending     <= pending_next;
            busy_cnt    <= cnt_next;
            wr_conflict <= conflict;
        end
    end

    // Reads are gated by rst_n so a forwarded write cannot leak out during reset.
    always_comb begin
        r_data = '0;
        r_busy = '0;
        bp_hit = '0;
        for (int i = 0; i < NREAD; i++) begin
            r_data[i] = regs[r_addr[i]];
            r_busy[i] = pending[r_addr[i]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (w_en[j] && (w_addr[j] == r_addr[i])) begin
                        r_data[i] = w_data[j];
                        bp_hit[i] = 1'b1;
                    end
                end
                if (bp_hit[i] && !(rsv_en && (rsv_addr == r_addr[i]))) r_busy[i] = 1'b0;
            end
            if (!rst_n) begin
                r_data[i] = '0;
                r_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: doc/simd_regfile_mp.md
Name: simd_regfile_mp

Overview:
Parametrised multi-port vector register file for the SIMD datapath. It supports configurable width, depth and read/write port counts, with per-port write enables and deterministic same-address write priority. Optional write-to-read bypass is selectable by parameter. An integrated pending-bit scoreboard tracks registers reserved by in-flight producers. It sits between the decode/issue stage, which reads operands and reserves destinations, and the execute lanes, which write back results.

Parameters:
DATA_W, 16, width of each register in bits
ADDR_W, 4, register address width; depth = 2**ADDR_W
NREAD, 8, number of read ports
NWRITE, 4, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see only stored state

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
r_addr  input  [ADDR_W-1:0] x NREAD  read addresses
r_data  output  [DATA_W-1:0] x NREAD  read data, combinational
r_busy  output  1 x NREAD  pending bit of addressed register, combinational
w_en  input  1 x NWRITE  per-port write enable
w_addr  input  [ADDR_W-1:0] x NWRITE  write addresses
w_data  input  [DATA_W-1:0] x NWRITE  write data
rsv_en  input  1  reserve request; sets pending bit of rsv_addr
rsv_addr  input  [ADDR_W-1:0]  register to reserve
busy_cnt  output  [ADDR_W:0]  number of pending registers, registered
wr_conflict  output  1  registered one-cycle pulse; two or more enabled write ports hit the same address in the previous cycle

Behaviour:
- Reset (rst_n low, asynchronous): all 2**ADDR_W registers cleared to 0, all pending bits cleared, busy_cnt=0, wr_conflict=0. While reset is asserted, r_data=0 and r_busy=0 for any address. Reset takes effect mid-operation with no partial writes retained.
- Write: at a rising clk, every port j with w_en[j]=1 writes w_data[j] to reg[w_addr[j]]. Latency 1; the stored value is visible to non-bypass reads from the next cycle.
- Write priority: if several enabled ports target the same address, the highest-index port wins. Losers are discarded. wr_conflict=1 for exactly the following cycle.
- Read: r_data[i] = reg[r_addr[i]] combinationally, with zero latency.
- Bypass (BYPASS=1): if any enabled write port matches r_addr[i] in the current cycle, r_data[i] = w_data of the highest-index matching port. BYPASS=0 returns the old stored value.
- Pending set/clear at the rising edge:
  - rsv_en=1 sets pending[rsv_addr].
  - Any enabled write to address a clears pending[a].
  - If reserve and write target the same address in the same cycle, the reserve wins and the bit ends at 1.
  - Reserving an already-pending register leaves it at 1, with no count change.
- r_busy[i] = pending[r_addr[i]]. With BYPASS=1 it is forced to 0 when a same-cycle enabled write matches r_addr[i] and rsv_en/rsv_addr do not match the same address.
- busy_cnt: registered population count of the pending bits after the edge's updates. Range 0..2**ADDR_W; reaching 2**ADDR_W is legal and does not wrap.
- Addresses are always in range by construction; no bounds checking.
- Simulation-only $display register dump on each edge is allowed, but must not affect synthesis.

Test Plan:
- Reset/readback: assert rst_n=0 mid-stream after writing R3=0x1234 -> all r_data=0, busy_cnt=0, wr_conflict=0; release, read R3 -> 0.
- Multi-port write: same cycle, w_en=4'b1111, addrs 1,2,5,9, data 11,22,55,99 -> next cycle reads of R1,R2,R5,R9 return 11,22,55,99 on all 8 read ports.
- Write conflict: ports 0 and 3 both write R7 with 0xAAAA and 0x5555 -> R7=0x5555, wr_conflict=1 for exactly one cycle, then 0.
- Bypass: BYPASS=1, R4=10 stored, write R4=77 while reading R4 -> r_data=77 that cycle. Rerun with BYPASS=0 -> 10 that cycle, 77 next.
- Scoreboard: reserve R2, R6 on consecutive cycles -> busy_cnt 1 then 2, r_busy(R6)=1. Write R6 with simultaneous rsv R6 -> pending stays set, busy_cnt=2. Write R2 -> busy_cnt=1.
- Full scoreboard: reserve all 16 registers -> busy_cnt=16, no wrap. Re-reserve R0 -> busy_cnt still 16.
